// File: rtl/fdam_rd_req_generator.sv
// ---------------------------------------------------------------------------
// fdam_rd_req_generator
//
// Generates the cache-line read-request address stream for one accelerator
// input queue. Software writes a base line address and a line count with a
// single-cycle start pulse; the block then issues at most one request per
// cycle towards the read-request arbiter.
//
// Issue is throttled by:
//   - req_rd_available_in : registered "not almost-full" flag from the arbiter
//   - a credit counter bounding lines requested but not yet popped from the
//     local response buffer to MAX_OUTSTANDING
// Returned lines are counted, and done is raised once every requested line
// has come back.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                single-cycle job start (ignored while busy)
//   base_addr, num_lines job configuration, latched on an accepted start
//   req_rd_available_in  arbiter can accept requests
//   req_rd_en            request valid (registered)
//   req_rd_data          requested line address (registered)
//   rd_resp_valid        one line returned to the local buffer
//   buf_pop              consumer removed one line (returns one credit)
//   busy                 job in progress (issuing or draining)
//   done                 job complete, held until next start or rst
//   issued_count         requests issued in the current job
// ---------------------------------------------------------------------------
module fdam_rd_req_generator #(
    parameter int ADDR_WIDTH      = 32,
    parameter int COUNT_WIDTH     = 32,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CREDIT_BITS     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] num_lines,
    input  logic                   req_rd_available_in,
    output logic                   req_rd_en,
    output logic [ADDR_WIDTH-1:0]  req_rd_data,
    input  logic                   rd_resp_valid,
    input  logic                   buf_pop,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] issued_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(MAX_OUTSTANDING);

    state_t                 state_reg;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  base_reg;
    logic [COUNT_WIDTH-1:0] num_reg;
    logic [COUNT_WIDTH-1:0] issued_reg;
    logic [COUNT_WIDTH-1:0] received_reg;
    logic [CREDIT_BITS-1:0] credit_reg;
    logic                   req_en_reg;
    logic [ADDR_WIDTH-1:0]  req_data_reg;

    logic                   start_ok;
    logic                   fire;
    logic [COUNT_WIDTH-1:0] issued_inc;

    // A start is only honoured when no job is running.
    assign start_ok   = start & ((state_reg == IDLE) | (state_reg == DONE));

    // The available flag is used as sampled: a low sample blocks this cycle.
    assign fire       = (state_reg == ISSUE) & req_rd_available_in &
                        (credit_reg != '0) & (issued_reg < num_reg);

    assign issued_inc = issued_reg + COUNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_next = (num_lines == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (fire && (issued_inc == num_reg)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (received_reg == num_reg) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Job configuration and progress counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            base_reg     <= '0;
            num_reg      <= '0;
            issued_reg   <= '0;
            received_reg <= '0;
        end else if (start_ok) begin
            // Clearing wins over a response landing in the same cycle.
            base_reg     <= base_addr;
            num_reg      <= num_lines;
            issued_reg   <= '0;
            received_reg <= '0;
        end else begin
            if (fire) begin
                issued_reg <= issued_inc;
            end
            // Responses ahead of the last issue are counted normally.
            if (rd_resp_valid && (state_reg != IDLE)) begin
                received_reg <= received_reg + COUNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered request outputs: one cycle from fire decision to req_rd_en.
    // Address wraps modulo 2**ADDR_WIDTH.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            req_en_reg   <= 1'b0;
            req_data_reg <= '0;
        end else begin
            req_en_reg <= fire;
            if (fire) begin
                req_data_reg <= base_reg + ADDR_WIDTH'(issued_reg);
            end
        end
    end

    // ------------------------------------------------------------------
    // Credit counter. Survives start so lines buffered from a previous job
    // keep their credits; a pop at full credit saturates instead of wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_reg <= CREDIT_MAX;
        end else begin
            case ({fire, buf_pop})
                2'b10: credit_reg <= credit_reg - CREDIT_BITS'(1);
                2'b01: begin
                    if (credit_reg != CREDIT_MAX) begin
                        credit_reg <= credit_reg + CREDIT_BITS'(1);
                    end
                end
                default: credit_reg <= credit_reg;
            endcase
        end
    end

    assign req_rd_en    = req_en_reg;
    assign req_rd_data  = req_data_reg;
    assign busy         = (state_reg == ISSUE) | (state_reg == DRAIN);
    assign done         = (state_reg == DONE);
    assign issued_count = issued_reg;

endmodule

// File: tb/tb_fdam_rd_req_generator.sv
// ---------------------------------------------------------------------------
// Testbench for fdam_rd_req_generator. A job-level reference model (job
// phase, issued/received counts, credit pool) predicts every output each
// cycle; responses and pops are generated from a simple model of the
// outstanding requests and buffered lines.
// ---------------------------------------------------------------------------
module tb_fdam_rd_req_generator;

    localparam int MAXO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] num_lines;
    logic        req_rd_available_in;
    logic        req_rd_en;
    logic [31:0] req_rd_data;
    logic        rd_resp_valid;
    logic        buf_pop;
    logic        busy;
    logic        done;
    logic [31:0] issued_count;

    fdam_rd_req_generator #(
        .ADDR_WIDTH(32), .COUNT_WIDTH(32), .MAX_OUTSTANDING(MAXO), .CREDIT_BITS(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_lines(num_lines), .req_rd_available_in(req_rd_available_in),
        .req_rd_en(req_rd_en), .req_rd_data(req_rd_data),
        .rd_resp_valid(rd_resp_valid), .buf_pop(buf_pop), .busy(busy),
        .done(done), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = no job yet, 1 = issuing, 2 = waiting for lines, 3 = complete
    int          ph = 0;
    logic [31:0] m_base = '0, m_num = '0, m_iss = '0, m_rec = '0, m_data = '0;
    logic        m_en = 1'b0;
    int          m_cred = MAXO;

    // Environment state
    int          owed = 0;        // requests issued, response not yet returned
    int          buffered = 0;    // lines returned, not yet popped
    bit          auto_resp = 1'b0, auto_pop = 1'b0, force_pop = 1'b0;
    int          resp_pct = 100, pop_pct = 100, av_pct = 100;
    logic [31:0] job_base = '0, job_num = '0;
    int          n_req_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic st, input logic av, input logic r);
        logic resp, pop, fire;
        int   nph;
        resp = auto_resp && (owed > 0) && ($urandom_range(0, 99) < resp_pct);
        pop  = force_pop || (auto_pop && (buffered > 0) && ($urandom_range(0, 99) < pop_pct));
        rst                 = r;
        start               = st;
        base_addr           = st ? job_base : $urandom;
        num_lines           = st ? job_num  : $urandom;
        req_rd_available_in = av;
        rd_resp_valid       = resp;
        buf_pop             = pop;
        @(posedge clk);
        if (r) begin
            ph = 0; m_base = '0; m_num = '0; m_iss = '0; m_rec = '0;
            m_en = 1'b0; m_data = '0; m_cred = MAXO; owed = 0; buffered = 0;
        end else begin
            fire = (ph == 1) && av && (m_cred > 0) && (m_iss < m_num);
            m_en = fire;
            if (fire) m_data = m_base + m_iss;
            if (fire && !pop) m_cred--;
            else if (pop && !fire && m_cred < MAXO) m_cred++;
            nph = ph;
            if (ph == 1 && fire && (m_iss + 32'd1 == m_num)) nph = 2;
            else if (ph == 2 && m_rec == m_num) nph = 3;
            if (ph != 0 && resp) m_rec++;
            if (fire) m_iss++;
            if ((ph == 0 || ph == 3) && st) begin
                m_base = job_base; m_num = job_num; m_iss = '0; m_rec = '0;
                nph = (job_num == 0) ? 3 : 1;
            end
            ph = nph;
            if (fire) owed++;
            if (resp) begin owed--; buffered++; end
            if (pop && buffered > 0) buffered--;
        end
        @(negedge clk);
        chk("req_rd_en",    {63'd0, req_rd_en}, {63'd0, m_en});
        chk("req_rd_data",  {32'd0, req_rd_data}, {32'd0, m_data});
        chk("busy",         {63'd0, busy}, {63'd0, (ph == 1 || ph == 2)});
        chk("done",         {63'd0, done}, {63'd0, (ph == 3)});
        chk("issued_count", {32'd0, issued_count}, {32'd0, m_iss});
        if (req_rd_en) begin
            n_req_seen++;
            $display("req addr=%08h issued=%0d t=%0t", req_rd_data, issued_count, $time);
        end
    endtask

    task automatic idle(input int n, input logic av);
        for (int i = 0; i < n; i++) cycle(1'b0, av, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic start_job(input logic [31:0] b, input logic [31:0] n);
        job_base = b; job_num = n;
        $display("start base=%08h num=%0d", b, n);
        cycle(1'b1, 1'b1, 1'b0);
    endtask

    task automatic run_done(input string tag, input int budget);
        int k;
        k = 0;
        while (ph != 3 && k < budget) begin
            cycle(1'b0, ($urandom_range(0, 99) < av_pct), 1'b0);
            k++;
        end
        chk(tag, {63'd0, done}, 64'd1);
    endtask

    initial begin
        do_reset(3);

        // Basic contiguous job
        auto_resp = 1; resp_pct = 50; auto_pop = 0; av_pct = 100;
        start_job(32'h100, 32'd4);
        run_done("basic_done", 80);
        chk("basic_issued", {32'd0, issued_count}, 64'd4);
        auto_pop = 1; pop_pct = 100;
        idle(6, 1'b1);

        // Credit limit, including a saturating pop at full credit
        do_reset(2);
        auto_pop = 0; resp_pct = 100;
        force_pop = 1; cycle(1'b0, 1'b1, 1'b0); force_pop = 0;
        start_job(32'h100, 32'd20);
        n_req_seen = 0;
        idle(40, 1'b1);
        chk("credit_cap", n_req_seen, 64'd16);
        force_pop = 1; cycle(1'b0, 1'b1, 1'b0); force_pop = 0;
        idle(5, 1'b1);
        chk("one_more_after_pop", n_req_seen, 64'd17);
        auto_pop = 1; pop_pct = 60;
        run_done("credit_done", 300);

        // Backpressure: drop available for 3 cycles after the 2nd request
        start_job(32'h2000, 32'd8);
        idle(2, 1'b1);
        idle(3, 1'b0);
        run_done("bp_done", 200);

        // Zero-length job and address wrap
        start_job(32'h7777, 32'd0);
        chk("zero_done", {63'd0, done}, 64'd1);
        idle(2, 1'b1);
        start_job(32'hFFFF_FFFE, 32'd3);
        run_done("wrap_done", 200);

        // Start while busy is ignored
        start_job(32'h3000, 32'd6);
        cycle(1'b0, 1'b1, 1'b0);
        job_base = 32'h9999; job_num = 32'd2;
        cycle(1'b1, 1'b1, 1'b0);
        run_done("busy_start_done", 200);
        chk("busy_start_issued", {32'd0, issued_count}, 64'd6);
        idle(10, 1'b1);

        // Fire and pop in the same cycle leave credits unchanged
        do_reset(1);
        auto_pop = 0; resp_pct = 100;
        start_job(32'h4000, 32'd30);
        n_req_seen = 0;
        idle(10, 1'b1);
        force_pop = 1; idle(4, 1'b1); force_pop = 0;
        idle(20, 1'b1);
        chk("fire_pop_cap", n_req_seen, 64'd20);
        auto_pop = 1; pop_pct = 70;
        run_done("fire_pop_done", 300);

        // Reset mid-job, then a fresh job sees the full credit pool
        start_job(32'h5000, 32'd10);
        idle(3, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        auto_pop = 0;
        start_job(32'h6000, 32'd20);
        n_req_seen = 0;
        idle(30, 1'b1);
        chk("rst_credit_cap", n_req_seen, 64'd16);
        auto_pop = 1;
        run_done("rst_done", 300);

        // Randomized jobs
        av_pct = 70; resp_pct = 60; pop_pct = 50;
        for (int j = 0; j < 8; j++) begin
            start_job($urandom, $urandom_range(0, 40));
            run_done("rand_done", 800);
            idle($urandom_range(0, 4), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
